// File: rtl/count_sched_pkg.sv
// count_sched_pkg: shared FSM state type, default sizing constants and id-width helper for count_job_sched
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_W     = 19;
    localparam int DEF_BOUND = 200;

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from pointer+1 with wrap; pointer is held by the parent
module rr_arbiter
    import count_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   pointer,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   id
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    // first requester after the pointer wins; nothing is granted while disabled
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, pointer} + (IW+1)'(k);
            idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/count_job_sched.sv
// count_job_sched: round-robin job scheduler sharing one bounded up-counter; COUNT_JOB_ABORT_EN adds abort/done_aborted
module count_job_sched
    import count_sched_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int W             = DEF_W,
    parameter int DEFAULT_BOUND = DEF_BOUND
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_bound,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    selector,
`ifdef COUNT_JOB_ABORT_EN
    input  logic                    abort,
    output logic                    done_aborted,
`endif
    output logic                    busy,
    output logic [id_w(NREQ)-1:0]   owner,
    output logic [W-1:0]            x,
    output logic [W-1:0]            n,
    output logic [W-1:0]            m,
    output logic                    done_valid,
    output logic [id_w(NREQ)-1:0]   done_id,
    output logic [W-1:0]            done_m,
    input  logic                    done_ready
);

    localparam int IW = id_w(NREQ);

    state_t        state, nxt;
    logic [IW-1:0] ptr, win_id;
    logic [W-1:0]  win_bound, load_bound;
    logic          accept, at_bound, abort_run;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .pointer (ptr),
        .enable  (state == IDLE),
        .grant   (req_ready),
        .id      (win_id)
    );

    assign accept     = |(req_valid & req_ready);
    assign at_bound   = x >= n;
    assign load_bound = (win_bound == '0) ? W'(DEFAULT_BOUND) : win_bound;

`ifdef COUNT_JOB_ABORT_EN
    assign abort_run = (state == RUN) && abort;
`else
    assign abort_run = 1'b0;
`endif

    // select the bound carried by the granted requester
    always_comb begin
        win_bound = '0;
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) win_bound = req_bound[i*W +: W];
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    // next state: grant starts a job, bound or abort ends it, consumer handshake retires it
    always_comb begin
        nxt = (state == IDLE) ? (accept ? RUN : IDLE) :
              (state == RUN)  ? ((at_bound || abort_run) ? REPORT : RUN) :
                                (done_ready ? IDLE : REPORT);
    end

    // outputs derived from state and held registers
    always_comb begin
        busy       = state != IDLE;
        done_valid = state == REPORT;
        done_id    = owner;
        done_m     = m;
    end

    // counter datapath, owner and round-robin pointer
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            x     <= '0;
            m     <= '0;
            n     <= W'(DEFAULT_BOUND);
            owner <= '0;
            ptr   <= IW'(NREQ - 1);
        end else if (accept) begin
            x     <= '0;
            m     <= '0;
            n     <= load_bound;
            owner <= win_id;
            ptr   <= win_id;
        end else if (state == RUN && !at_bound && !abort_run) begin
            x <= x + W'(1);
            if (selector) m <= x;
        end

`ifdef COUNT_JOB_ABORT_EN
    // sticky abort flag for the current job, cleared by the next grant
    always_ff @(posedge clk or posedge rst)
        if (rst)            done_aborted <= 1'b0;
        else if (accept)    done_aborted <= 1'b0;
        else if (abort_run) done_aborted <= 1'b1;
`endif

endmodule
